// File: rtl/blink_pkg.sv
// Shared definitions for the blink sequencer.
// Contents:
//   state_t          FSM state encoding (StIdle=0, StOn=1, StOff=2, StDone=3)
//   DefaultPrescale  clk cycles per timing tick for the 50 MHz board clock (1 ms)
package blink_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2,
        StDone = 2'd3
    } state_t;

    localparam int unsigned DefaultPrescale = 50000;

endpackage

// File: rtl/tick_prescaler.sv
// Timing-tick generator: a down-counter that asserts tick for one cycle every PRESCALE
// clk cycles. clr reloads the counter so the first tick lands exactly PRESCALE cycles later.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   clr    in   restart the count
//   tick   out  1-cycle strobe every PRESCALE cycles
module tick_prescaler #(
    parameter int unsigned PRESCALE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    // Keep at least one bit so PRESCALE=1 still elaborates (tick is then always high).
    localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || (cnt_q == '0)) begin
            cnt_q <= Reload;
        end else begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/blink_sequencer.sv
// Blink sequencer: produces a burst of N on/off blinks (or continuous blinking when N=0)
// timed by a shared prescaler tick. All outputs are registered.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   start      in   1-cycle request; latches config and starts a sequence when idle
//   stop       in   1-cycle abort back to idle (highest priority)
//   on_ticks   in   ON phase length in ticks (0 treated as 1)
//   off_ticks  in   OFF phase length in ticks (0 treated as 1)
//   pulses     in   blink count, 0 = continuous
//   salida     out  blink output, high during ON
//   toggle     out  1-cycle strobe whenever salida changes
//   busy       out  high while a sequence is active (including the done cycle)
//   done       out  1-cycle pulse when a finite burst completes
module blink_sequencer import blink_pkg::*; #(
    parameter int unsigned PRESCALE = DefaultPrescale,
    parameter int unsigned TW       = 16,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [TW-1:0] on_ticks,
    input  logic [TW-1:0] off_ticks,
    input  logic [CW-1:0] pulses,
    output logic          salida,
    output logic          toggle,
    output logic          busy,
    output logic          done
);

    state_t        state_q;
    logic [TW-1:0] on_q, off_q, ph_cnt_q;
    logic [CW-1:0] rem_q;
    logic          salida_q, toggle_q, busy_q, done_q;
    logic          tick, start_acc;
    logic [TW-1:0] on_norm, off_norm;

    assign on_norm   = (on_ticks  == '0) ? TW'(1) : on_ticks;
    assign off_norm  = (off_ticks == '0) ? TW'(1) : off_ticks;
    assign start_acc = (state_q == StIdle) && start && !stop;

    // Restarting the prescaler on start keeps every phase boundary on a tick edge.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_acc),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            on_q     <= '0;
            off_q    <= '0;
            ph_cnt_q <= '0;
            rem_q    <= '0;
            salida_q <= 1'b0;
            toggle_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            toggle_q <= 1'b0;
            done_q   <= 1'b0;
            if (stop) begin
                state_q  <= StIdle;
                salida_q <= 1'b0;
                busy_q   <= 1'b0;
                toggle_q <= salida_q;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            on_q     <= on_norm;
                            off_q    <= off_norm;
                            rem_q    <= pulses;
                            ph_cnt_q <= on_norm;
                            state_q  <= StOn;
                            salida_q <= 1'b1;
                            toggle_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    StOn: begin
                        if (tick) begin
                            if (ph_cnt_q == TW'(1)) begin
                                ph_cnt_q <= off_q;
                                state_q  <= StOff;
                                salida_q <= 1'b0;
                                toggle_q <= 1'b1;
                            end else begin
                                ph_cnt_q <= ph_cnt_q - TW'(1);
                            end
                        end
                    end
                    StOff: begin
                        if (tick) begin
                            if (ph_cnt_q != TW'(1)) begin
                                ph_cnt_q <= ph_cnt_q - TW'(1);
                            end else if (rem_q == CW'(1)) begin
                                rem_q   <= '0;
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                // rem_q == 0 marks continuous mode and is never decremented.
                                if (rem_q != '0) begin
                                    rem_q <= rem_q - CW'(1);
                                end
                                ph_cnt_q <= on_q;
                                state_q  <= StOn;
                                salida_q <= 1'b1;
                                toggle_q <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign salida = salida_q;
    assign toggle = toggle_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_blink_sequencer.sv
module tb_blink_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] on_ticks = '0;
    logic [15:0] off_ticks = '0;
    logic [7:0]  pulses = '0;
    logic        s0, t0, b0, d0;
    logic        s1, t1, b1, d1;

    int          total = 0;
    int          passed = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_v, obs;
    logic        sel1 = 1'b0;

    always #5 clk = ~clk;

    // PRESCALE=2 instance for most scenarios.
    blink_sequencer #(.PRESCALE(2), .TW(16), .CW(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .on_ticks(on_ticks), .off_ticks(off_ticks), .pulses(pulses),
        .salida(s0), .toggle(t0), .busy(b0), .done(d0)
    );

    // PRESCALE=1 instance for the continuous-mode scenario.
    blink_sequencer #(.PRESCALE(1), .TW(16), .CW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .on_ticks(on_ticks), .off_ticks(off_ticks), .pulses(pulses),
        .salida(s1), .toggle(t1), .busy(b1), .done(d1)
    );

    // Expected {salida, toggle, busy, done} per cycle, n copies.
    task automatic push(input logic [3:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        sel1 = 1'b0;
        push(4'b0000, 3);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL reset_hold cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        rst_n = 1'b1;
        push(4'b0000, 3);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL reset_release cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        total++;
        if ({s1, t1, b1, d1} !== 4'b0000)
            $display("FAIL reset_dut1: got %b want 0000", {s1, t1, b1, d1});
        else passed++;
    endtask

    task automatic test_burst();
        int cyc;
        int ntog;
        sel1 = 1'b0;
        on_ticks = 16'd3; off_ticks = 16'd2; pulses = 8'd2; start = 1'b1;
        for (int b = 0; b < 2; b++) begin
            push(4'b1110, 1); push(4'b1010, 5);
            push(4'b0110, 1); push(4'b0010, 3);
        end
        push(4'b0011, 1); push(4'b0000, 2);
        cyc = 0; ntog = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            if (t0 === 1'b1) ntog++;
            total++;
            if (obs !== exp_v) $display("FAIL burst cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        total++;
        if (ntog !== 4) $display("FAIL burst_toggles: got %0d want 4", ntog);
        else passed++;
    endtask

    task automatic test_continuous();
        int cyc;
        sel1 = 1'b1;
        on_ticks = 16'd1; off_ticks = 16'd1; pulses = 8'd0; start = 1'b1;
        for (int i = 1; i <= 21; i++) push((i % 2 == 1) ? 4'b1110 : 4'b0110, 1);
        push(4'b0100, 1);   // stop while salida high: one falling toggle, no done
        push(4'b0000, 3);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            exp_v = exp_q.pop_front();
            obs = {s1, t1, b1, d1};
            total++;
            if (obs !== exp_v) $display("FAIL continuous cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
            start = 1'b0;
            stop = (cyc == 21);
        end
        sel1 = 1'b0;
    endtask

    task automatic test_start_stop_and_ignore();
        int cyc;
        on_ticks = 16'd1; off_ticks = 16'd1; pulses = 8'd1;
        start = 1'b1; stop = 1'b1;
        push(4'b0000, 3);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; stop = 1'b0;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL start_stop cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        on_ticks = 16'd4; off_ticks = 16'd1; pulses = 8'd1; start = 1'b1;
        push(4'b1110, 1); push(4'b1010, 7);
        push(4'b0110, 1); push(4'b0010, 1);
        push(4'b0011, 1); push(4'b0000, 2);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL ignore_start cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
            // Second start with different config lands mid-burst and must be ignored.
            start = (cyc == 2);
            if (cyc == 2) begin
                on_ticks = 16'd1; off_ticks = 16'd1; pulses = 8'd5;
            end
        end
    endtask

    task automatic test_zero_ticks();
        int cyc;
        on_ticks = 16'd0; off_ticks = 16'd0; pulses = 8'd1; start = 1'b1;
        push(4'b1110, 1); push(4'b1010, 1);
        push(4'b0110, 1); push(4'b0010, 1);
        push(4'b0011, 1); push(4'b0000, 2);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL zero_ticks cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        on_ticks = 16'd5; off_ticks = 16'd1; pulses = 8'd3; start = 1'b1;
        push(4'b1110, 1); push(4'b1010, 2);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL pre_reset cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (s0 !== 1'b0) $display("FAIL async_salida: got %b want 0", s0);
        else passed++;
        total++;
        if (b0 !== 1'b0) $display("FAIL async_busy: got %b want 0", b0);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(4'b0000, 4);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL post_reset_idle cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
        on_ticks = 16'd1; off_ticks = 16'd1; pulses = 8'd1; start = 1'b1;
        push(4'b1110, 1); push(4'b1010, 1);
        push(4'b0110, 1); push(4'b0010, 1);
        push(4'b0011, 1); push(4'b0000, 1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            exp_v = exp_q.pop_front();
            obs = {s0, t0, b0, d0};
            total++;
            if (obs !== exp_v) $display("FAIL restart cyc%0d: got %b want %b", cyc, obs, exp_v);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_continuous();
        test_start_stop_and_ignore();
        test_zero_ticks();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
